muskoka_rst_ctrl: RTL and testbench
===================================

# muskoka_rst_ctrl

Reset controller inside the muskoka SoC that consumes the board or testbench clock and reset and produces the SoC's internal reset tree. It synchronizes reset deassertion and holds the peripheral and CPU domains in reset for programmable periods, releasing peripherals before the moxie core. It also merges software and watchdog reset requests and records the cause of the last reset.

## Interface
- SYNC_STAGES, 2, depth of the reset deassertion synchronizer (minimum 2).
- PERIPH_HOLD, 16, cycles the peripheral reset is held after the synchronized release.
- CPU_STAGGER, 4, additional cycles the CPU reset is held after the peripheral release.
- clk_i  input  1  SoC clock.
- rst_i  input  1  external reset, asynchronous, active-low.
- sw_rst_req_i  input  1  software reset request, single-cycle pulse, synchronous.
- wdt_bite_i  input  1  watchdog reset request, level or pulse, synchronous.
- periph_rst_o  output  1  active-high reset to bus and peripherals; reset value 1.
- cpu_rst_o  output  1  active-high reset to the moxie core; reset value 1.
- rst_done_o  output  1  high once both domains are released; reset value 0.
- rst_cause_o  output  2  last reset cause (0 power-on/external, 1 software, 2 watchdog, 3 reserved); reset value 0.

## Operation
- rst_i low asynchronously forces state RESET, both resets high, rst_done_o low, rst_cause_o = 0, and clears the synchronizer and counter.
- The synchronizer shifts in 1 while rst_i is high. Its last stage is sync_ok.
- FSM states:
  - RESET: go to SYNC when sync_ok = 1.
  - SYNC: load counter = PERIPH_HOLD-1, go to HOLD_P.
  - HOLD_P: decrement; at 0, drop periph_rst_o, load counter = CPU_STAGGER-1, go to HOLD_C.
  - HOLD_C: decrement; at 0, drop cpu_rst_o, raise rst_done_o, go to RUN.
  - RUN: idle until a request arrives.
- Soft reset: in any state other than RESET, sw_rst_req_i or wdt_bite_i causes the following on the next edge.
  - Both resets and rst_done_o are reasserted, and the FSM goes to SYNC. The synchronizer is not cleared.
  - rst_cause_o is updated: watchdog has priority over software when both are asserted.
- rst_cause_o keeps its value across soft resets. Only rst_i clears it.
- A request arriving during HOLD_P or HOLD_C restarts the full sequence from SYNC. The counter is reloaded.
- wdt_bite_i held high keeps the FSM in SYNC. Release proceeds once it drops.
- Counter width is clog2(max(PERIPH_HOLD, CPU_STAGGER)). PERIPH_HOLD and CPU_STAGGER must be at least 1.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- External release:
  - rst_i rises before edge 0; sync_ok = 1 after SYNC_STAGES edges, and the FSM enters SYNC on the next edge.
  - periph_rst_o falls PERIPH_HOLD edges after entering HOLD_P.
  - cpu_rst_o and rst_done_o fall/rise together CPU_STAGGER edges later.
  - With defaults, cpu_rst_o falls 2+1+1+16+4 = 24 edges after rst_i rises, ±1 edge for metastability.
- Soft request: resets are high on the edge after the request. Release then follows SYNC → HOLD_P → HOLD_C, i.e. 1+PERIPH_HOLD+CPU_STAGGER edges, with no synchronizer delay.
- Assertion via rst_i is immediate and asynchronous. Deassertion is always synchronous to clk_i.

## Structure
- Shared package muskoka_pkg holds the state enum (RESET, SYNC, HOLD_P, HOLD_C, RUN) and the cause constants RST_CAUSE_POR/SW/WDT.
- One sub-module, muskoka_rst_sync: a parameterized SYNC_STAGES flop chain with async clear, reusable for other clock domains.
- The top-level SoC wires clk_i and rst_i into this block only. All other muskoka blocks take periph_rst_o or cpu_rst_o.

## Test plan
- Power-on: rst_i low 10 cycles, then high with defaults. Expect:
  - periph_rst_o falls around edge 20 and cpu_rst_o/rst_done_o around edge 24.
  - rst_cause_o = 0.
- Software reset: in RUN, 1-cycle sw_rst_req_i. Expect:
  - Both resets high on the next edge.
  - periph release 17 edges later, cpu 4 edges after that.
  - rst_cause_o = 1.
- Watchdog priority: sw_rst_req_i and wdt_bite_i high in the same cycle → rst_cause_o = 2. Then a software reset → cause becomes 1.
- Mid-sequence restart: wdt_bite_i pulsed during HOLD_C (counter = 2). Expect:
  - cpu_rst_o stays high and periph_rst_o reasserts.
  - Counter reloads to 15 and release restarts from SYNC.
- Async abort: drive rst_i low mid-cycle during RUN after a watchdog reset. Expect both resets high before the next clock edge, rst_done_o = 0 and rst_cause_o = 0.
- Parameter corner: PERIPH_HOLD = 1, CPU_STAGGER = 1, SYNC_STAGES = 3. Expect cpu_rst_o to fall exactly one edge after periph_rst_o, with no underflow or wrap of the counter.

Source files
------------

// File: rtl/muskoka_pkg.sv
// Shared types and constants for the muskoka reset controller.
package muskoka_pkg;

    typedef enum logic [2:0] {
        RESET,
        SYNC,
        HOLD_P,
        HOLD_C,
        RUN
    } rst_state_e;

    localparam logic [1:0] RST_CAUSE_POR = 2'd0;
    localparam logic [1:0] RST_CAUSE_SW  = 2'd1;
    localparam logic [1:0] RST_CAUSE_WDT = 2'd2;

    function automatic int hold_cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/muskoka_rst_sync.sv
// Reset-release synchronizer: asserts asynchronously, releases after STAGES edges.
module muskoka_rst_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic sync_o
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], 1'b1};
        end
    end

    assign sync_o = chain[STAGES-1];

endmodule

// File: rtl/muskoka_rst_ctrl.sv
// SoC reset controller: synchronized release, staggered periph/CPU hold,
// software/watchdog soft resets and last-cause recording.
module muskoka_rst_ctrl
    import muskoka_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int PERIPH_HOLD = 16,
    parameter int CPU_STAGGER = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       sw_rst_req_i,
    input  logic       wdt_bite_i,
    output logic       periph_rst_o,
    output logic       cpu_rst_o,
    output logic       rst_done_o,
    output logic [1:0] rst_cause_o
);

    localparam int CNT_W = hold_cnt_width(PERIPH_HOLD, CPU_STAGGER);
    localparam logic [CNT_W-1:0] P_LOAD = CNT_W'(PERIPH_HOLD - 1);
    localparam logic [CNT_W-1:0] C_LOAD = CNT_W'(CPU_STAGGER - 1);

    rst_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             periph_d, cpu_d, done_d;
    logic [1:0]       cause_d;
    logic             sync_ok;

    muskoka_rst_sync #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .sync_o (sync_ok)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= RESET;
            cnt_q        <= '0;
            periph_rst_o <= 1'b1;
            cpu_rst_o    <= 1'b1;
            rst_done_o   <= 1'b0;
            rst_cause_o  <= RST_CAUSE_POR;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            periph_rst_o <= periph_d;
            cpu_rst_o    <= cpu_d;
            rst_done_o   <= done_d;
            rst_cause_o  <= cause_d;
        end
    end

    // Soft requests override the sequence from any post-RESET state.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        periph_d = periph_rst_o;
        cpu_d    = cpu_rst_o;
        done_d   = rst_done_o;
        cause_d  = rst_cause_o;
        if (state_q != RESET && (sw_rst_req_i || wdt_bite_i)) begin
            state_d  = SYNC;
            periph_d = 1'b1;
            cpu_d    = 1'b1;
            done_d   = 1'b0;
            cause_d  = wdt_bite_i ? RST_CAUSE_WDT : RST_CAUSE_SW;
        end else begin
            case (state_q)
                RESET: begin
                    if (sync_ok) begin
                        state_d = SYNC;
                    end
                end
                SYNC: begin
                    cnt_d   = P_LOAD;
                    state_d = HOLD_P;
                end
                HOLD_P: begin
                    if (cnt_q == '0) begin
                        periph_d = 1'b0;
                        cnt_d    = C_LOAD;
                        state_d  = HOLD_C;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                HOLD_C: begin
                    if (cnt_q == '0) begin
                        cpu_d   = 1'b0;
                        done_d  = 1'b1;
                        state_d = RUN;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                RUN: begin
                end
                default: begin
                    state_d = RESET;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muskoka_rst_ctrl.sv
// Directed bench for muskoka_rst_ctrl: default instance plus a minimum-hold corner instance.
module tb_muskoka_rst_ctrl;

    logic       clk;
    logic       rst;
    logic       sw_req;
    logic       wdt;
    logic       periph, cpu, done;
    logic [1:0] cause;
    logic       periph2, cpu2, done2;
    logic [1:0] cause2;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    muskoka_rst_ctrl dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .sw_rst_req_i (sw_req),
        .wdt_bite_i   (wdt),
        .periph_rst_o (periph),
        .cpu_rst_o    (cpu),
        .rst_done_o   (done),
        .rst_cause_o  (cause)
    );

    muskoka_rst_ctrl #(
        .SYNC_STAGES (3),
        .PERIPH_HOLD (1),
        .CPU_STAGGER (1)
    ) dut_min (
        .clk_i        (clk),
        .rst_i        (rst),
        .sw_rst_req_i (sw_req),
        .wdt_bite_i   (wdt),
        .periph_rst_o (periph2),
        .cpu_rst_o    (cpu2),
        .rst_done_o   (done2),
        .rst_cause_o  (cause2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int step, input logic [1:0] obs, input logic [1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s step %0d: observed %0d expected %0d", tag, step, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse a request for one cycle, then track the release: periph drops
    // after 17 edges, cpu/done after 21.
    task automatic soft_release(input logic s, input logic w, input logic [1:0] exp_cause, input string tag);
        sw_req = s;
        wdt    = w;
        tick();
        sw_req = 1'b0;
        wdt    = 1'b0;
        chk({tag, "_periph_hi"}, 0, periph, 1'b1);
        chk({tag, "_cpu_hi"},    0, cpu,    1'b1);
        chk({tag, "_done_lo"},   0, done,   1'b0);
        chk({tag, "_cause"},     0, cause,  exp_cause);
        for (int k = 1; k <= 23; k++) begin
            tick();
            chk({tag, "_periph"}, k, periph, (k < 17) ? 1'b1 : 1'b0);
            chk({tag, "_cpu"},    k, cpu,    (k < 21) ? 1'b1 : 1'b0);
            chk({tag, "_done"},   k, done,   (k >= 21) ? 1'b1 : 1'b0);
        end
        chk({tag, "_cause_kept"}, 0, cause, exp_cause);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1);
    end

    initial begin
        rst    = 1'b0;
        sw_req = 1'b0;
        wdt    = 1'b0;

        // Power-on: held in reset 10 cycles; requests ignored while in RESET.
        for (int k = 0; k < 10; k++) tick();
        chk("rst_periph", 0, periph, 1'b1);
        chk("rst_cpu",    0, cpu,    1'b1);
        chk("rst_done",   0, done,   1'b0);
        chk("rst_cause",  0, cause,  2'd0);
        chk("rst_min_periph", 0, periph2, 1'b1);
        chk("rst_min_cpu",    0, cpu2,    1'b1);

        rst = 1'b1;
        for (int n = 1; n <= 28; n++) begin
            tick();
            chk("po_periph", n, periph, (n < 20) ? 1'b1 : 1'b0);
            chk("po_cpu",    n, cpu,    (n < 24) ? 1'b1 : 1'b0);
            chk("po_done",   n, done,   (n >= 24) ? 1'b1 : 1'b0);
            chk("po_min_periph", n, periph2, (n < 6) ? 1'b1 : 1'b0);
            chk("po_min_cpu",    n, cpu2,    (n < 7) ? 1'b1 : 1'b0);
            chk("po_min_done",   n, done2,   (n >= 7) ? 1'b1 : 1'b0);
        end
        chk("po_cause", 0, cause, 2'd0);
        chk("po_min_cause", 0, cause2, 2'd0);

        // Software reset from RUN.
        soft_release(1'b1, 1'b0, 2'd1, "sw");

        // Simultaneous requests: watchdog wins; then software overwrites.
        soft_release(1'b1, 1'b1, 2'd2, "both");
        soft_release(1'b1, 1'b0, 2'd1, "sw2");

        // Mid-sequence restart: bite while in HOLD_C with counter at 2.
        sw_req = 1'b1;
        tick();
        sw_req = 1'b0;
        for (int k = 1; k <= 18; k++) tick();
        chk("mid_pre_periph", 0, periph, 1'b0);
        chk("mid_pre_cpu",    0, cpu,    1'b1);
        soft_release(1'b0, 1'b1, 2'd2, "mid");

        // Watchdog held high keeps the controller in SYNC.
        wdt = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("hold_periph", k, periph, 1'b1);
            chk("hold_cpu",    k, cpu,    1'b1);
        end
        soft_release(1'b0, 1'b1, 2'd2, "held");

        // Async abort mid-cycle in RUN after a watchdog reset.
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("abort_periph", 0, periph, 1'b1);
        chk("abort_cpu",    0, cpu,    1'b1);
        chk("abort_done",   0, done,   1'b0);
        chk("abort_cause",  0, cause,  2'd0);
        chk("abort_min_cpu", 0, cpu2,  1'b1);
        for (int k = 0; k < 3; k++) tick();
        rst = 1'b1;
        for (int n = 1; n <= 24; n++) tick();
        chk("rerel_cpu",   0, cpu,   1'b0);
        chk("rerel_done",  0, done,  1'b1);
        chk("rerel_cause", 0, cause, 2'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
